bk_add_seq_ctrl: RTL and testbench

//  Sequencing stage directly upstream of the 12-bit combinational Brent-Kung adder.

---
 rtl/bk_add_pkg.sv | 38 +++
 rtl/bk_operand_pack.sv | 41 ++++
 rtl/bk_add_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_bk_add_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_add_pkg.sv
// Shared types and bus helpers for the Brent-Kung adder sequencing stage.
package bk_add_pkg;

   localparam int ADD_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      HOLD  = 2'd3
   } bk_state_t;

   typedef struct packed {
      logic             carry;
      logic [ADD_W-1:0] sum;
   } bk_result_t;

   // Adder input bus: even bits carry operand A, odd bits carry operand B.
   function automatic logic [2*ADD_W-1:0] interleave(input logic [ADD_W-1:0] a,
                                                     input logic [ADD_W-1:0] b);
      logic [2*ADD_W-1:0] r;
      r = '0;
      for (int i = 0; i < ADD_W; i++) begin
         r[2*i]   = a[i];
         r[2*i+1] = b[i];
      end
      return r;
   endfunction

   // Adder output bus: top bit is the carry out, the rest is the sum.
   function automatic bk_result_t split(input logic [ADD_W:0] o);
      bk_result_t r;
      r.carry = o[ADD_W];
      r.sum   = o[ADD_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/bk_operand_pack.sv
// Owns the adder input register: loads either the fresh operand pair or the
// first-pass sum with a +1 operand for the carry-in pass, otherwise holds.
module bk_operand_pack
   import bk_add_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load_ops,
   input  logic               load_pass2,
   input  logic [ADD_W-1:0]   op_a,
   input  logic [ADD_W-1:0]   op_b,
   input  logic [ADD_W-1:0]   pass1_sum,
   output logic [2*ADD_W-1:0] add_in
);

   localparam logic [ADD_W-1:0] ONE = {{(ADD_W-1){1'b0}}, 1'b1};

   logic [2*ADD_W-1:0] add_in_q, add_in_d;

   // Select the next bus value; the bus only moves on a load so the adder never toggles idly.
   always_comb begin
      add_in_d = add_in_q;
      if (load_ops) begin
         add_in_d = interleave(op_a, op_b);
      end else if (load_pass2) begin
         add_in_d = interleave(pass1_sum, ONE);
      end
   end

   // Adder input register.
   always_ff @(posedge clk) begin
      if (rst) begin
         add_in_q <= '0;
      end else begin
         add_in_q <= add_in_d;
      end
   end

   assign add_in = add_in_q;

endmodule

// File: rtl/bk_add_seq_ctrl.sv
// Sequencer in front of the combinational 12-bit Brent-Kung adder. Feeds operand
// words, waits SETTLE_CYCLES per pass, and runs a second +1 pass when a carry
// must be chained in from the previous word of a multi-word transaction.
module bk_add_seq_ctrl
   import bk_add_pkg::*;
#(
   parameter int ADD_W         = 12,
   parameter int SETTLE_CYCLES = 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADD_W-1:0]   in_a,
   input  logic [ADD_W-1:0]   in_b,
   input  logic               in_first,
   input  logic               in_last,
   output logic [2*ADD_W-1:0] add_in,
   input  logic [ADD_W:0]     add_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADD_W-1:0]   out_sum,
   output logic               out_carry,
   output logic               out_last
);

   localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   bk_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             carry_in_q, carry_in_d;
   logic             last_q, last_d;
   logic             c1_q, c1_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [ADD_W-1:0] out_sum_q, out_sum_d;
   logic             out_carry_q, out_carry_d;
   logic             out_last_q, out_last_d;

   logic             accept;
   logic             settled;
   logic             load_ops;
   logic             load_pass2;
   bk_result_t       res;

   // in_ready_q is only ever set while the FSM is idle.
   assign accept  = in_valid & in_ready_q;
   assign settled = (cnt_q == '0);
   assign res     = split(add_out);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one or two settle-timed passes, then hold until consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept)    state_d = PASS1;
         PASS1: if (settled)   state_d = carry_in_q ? PASS2 : HOLD;
         PASS2: if (settled)   state_d = HOLD;
         HOLD:  if (out_ready) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   // Output and datapath next values for each state.
   always_comb begin
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      carry_in_d  = carry_in_q;
      last_d      = last_q;
      c1_d        = c1_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_carry_d = out_carry_q;
      out_last_d  = out_last_q;
      load_ops    = 1'b0;
      load_pass2  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               load_ops   = 1'b1;
               cnt_d      = CNT_LOAD;
               carry_in_d = in_first ? 1'b0 : carry_q;
               last_d     = in_last;
            end
         end
         PASS1: begin
            if (!settled) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (carry_in_q) begin
               // The adder has no carry-in, so add the chained carry as a second pass.
               c1_d       = res.carry;
               load_pass2 = 1'b1;
               cnt_d      = CNT_LOAD;
            end else begin
               out_sum_d   = res.sum;
               out_carry_d = res.carry;
               out_last_d  = last_q;
               out_valid_d = 1'b1;
            end
         end
         PASS2: begin
            if (!settled) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               out_sum_d   = res.sum;
               out_carry_d = c1_q | res.carry;
               out_last_d  = last_q;
               out_valid_d = 1'b1;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               // The chain ends at the last word; the next transaction starts clean.
               carry_d     = out_last_q ? 1'b0 : out_carry_q;
            end
         end
         default: ;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   // Datapath and handshake registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_in_q  <= 1'b0;
         last_q      <= 1'b0;
         c1_q        <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_carry_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         carry_in_q  <= carry_in_d;
         last_q      <= last_d;
         c1_q        <= c1_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_carry_q <= out_carry_d;
         out_last_q  <= out_last_d;
      end
   end

   // Width must match the adder; a +1 pass can never carry when the first pass did.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (ADD_W == bk_add_pkg::ADD_W);
         if (state_q == PASS2 && settled) begin
            assert (!(c1_q && res.carry));
         end
      end
   end

   bk_operand_pack u_pack (
      .clk        (clk),
      .rst        (rst),
      .load_ops   (load_ops),
      .load_pass2 (load_pass2),
      .op_a       (in_a),
      .op_b       (in_b),
      .pass1_sum  (res.sum),
      .add_in     (add_in)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_carry = out_carry_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_bk_add_seq_ctrl.sv
// Bench for bk_add_seq_ctrl: two instances (settle 1 and 3), each with a behavioural adder.
module tb_bk_add_seq_ctrl;

   localparam int W = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         in_valid, in_first, in_last, out_ready;
   logic [W-1:0] in_a, in_b;
   int           sel;

   logic           iv1, r1, ov1, oc1, ol1;
   logic [W-1:0]   os1;
   logic [2*W-1:0] ai1;
   logic [W:0]     ao1;
   logic           iv3, r3, ov3, oc3, ol3;
   logic [W-1:0]   os3;
   logic [2*W-1:0] ai3;
   logic [W:0]     ao3;

   int checks   = 0;
   int failures = 0;

   function automatic logic [W:0] adder_model(input logic [2*W-1:0] bus);
      logic [W-1:0] a, b;
      a = '0;
      b = '0;
      for (int i = 0; i < W; i++) begin
         a[i] = bus[2*i];
         b[i] = bus[2*i+1];
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [2*W-1:0] ilv(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         r[2*i]   = a[i];
         r[2*i+1] = b[i];
      end
      return r;
   endfunction

   assign ao1 = adder_model(ai1);
   assign ao3 = adder_model(ai3);
   assign iv1 = in_valid & (sel == 1);
   assign iv3 = in_valid & (sel == 3);

   bk_add_seq_ctrl #(.ADD_W(W), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(r1), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last), .add_in(ai1), .add_out(ao1),
      .out_valid(ov1), .out_ready(out_ready), .out_sum(os1), .out_carry(oc1), .out_last(ol1));

   bk_add_seq_ctrl #(.ADD_W(W), .SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(r3), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last), .add_in(ai3), .add_out(ao3),
      .out_valid(ov3), .out_ready(out_ready), .out_sum(os3), .out_carry(oc3), .out_last(ol3));

   logic           o_ready, o_valid, o_carry, o_last;
   logic [W-1:0]   o_sum;
   logic [2*W-1:0] o_add_in;
   assign o_ready  = (sel == 3) ? r3  : r1;
   assign o_valid  = (sel == 3) ? ov3 : ov1;
   assign o_sum    = (sel == 3) ? os3 : os1;
   assign o_carry  = (sel == 3) ? oc3 : oc1;
   assign o_last   = (sel == 3) ? ol3 : ol1;
   assign o_add_in = (sel == 3) ? ai3 : ai1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One word through the selected instance; hold>0 keeps out_ready low that many cycles.
   task automatic do_word(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic f, input logic l, input int hold, input logic [W-1:0] exp_s,
                          output logic [W-1:0] sum, output logic cy, output logic lst,
                          output int lat);
      int n;
      @(negedge clk);
      sel = s; in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!o_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("add_in_load", {8'd0, o_add_in}, {8'd0, ilv(a, b)});
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat < s) chk("add_in_held", {8'd0, o_add_in}, {8'd0, ilv(a, b)});
      end while (!o_valid && lat < 20);
      sum = o_sum; cy = o_carry; lst = o_last;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, o_valid}, 32'd1);
         chk("bp_sum", {20'd0, o_sum}, {20'd0, exp_s});
         chk("bp_in_ready", {31'd0, o_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      if (hold > 0) begin
         @(negedge clk);
         chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
         chk("bp_release_valid", {31'd0, o_valid}, 32'd0);
      end
   endtask

   typedef struct {
      logic [W-1:0] a, b;
      logic         f, l;
      logic [W-1:0] s;
      logic         c;
      int           lat;
   } vec_t;

   vec_t vt[12];
   logic [W-1:0] sum;
   logic         cy, lst;
   int           lat;
   logic [W-1:0] ra[4], rb[4];
   logic [63:0]  wa, wb, wt, part, m;
   logic [W-1:0] es;
   logic         ec, prevc;
   int           nw, s;

   initial begin
      vt[0]  = '{12'h001, 12'h002, 1'b0, 1'b1, 12'h003, 1'b0, 1};
      vt[1]  = '{12'hFFF, 12'h001, 1'b1, 1'b1, 12'h000, 1'b1, 1};
      vt[2]  = '{12'hFFF, 12'h001, 1'b1, 1'b0, 12'h000, 1'b1, 1};
      vt[3]  = '{12'h7FF, 12'h800, 1'b0, 1'b1, 12'h000, 1'b1, 2};
      vt[4]  = '{12'h001, 12'h001, 1'b1, 1'b1, 12'h002, 1'b0, 1};
      vt[5]  = '{12'h0FF, 12'hF00, 1'b1, 1'b0, 12'hFFF, 1'b0, 1};
      vt[6]  = '{12'h000, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1};
      vt[7]  = '{12'h800, 12'h800, 1'b1, 1'b0, 12'h000, 1'b1, 1};
      vt[8]  = '{12'h123, 12'h456, 1'b1, 1'b1, 12'h579, 1'b0, 1};
      vt[9]  = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 12'hFFE, 1'b1, 1};
      vt[10] = '{12'h000, 12'h000, 1'b0, 1'b0, 12'h001, 1'b0, 2};
      vt[11] = '{12'h123, 12'h000, 1'b0, 1'b1, 12'h123, 1'b0, 1};

      sel = 1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, r1}, 32'd0);
      chk("rst_out_valid", {31'd0, ov1}, 32'd0);
      chk("rst_add_in", {8'd0, ai1}, 32'd0);
      chk("rst_out_sum", {20'd0, os1}, 32'd0);
      chk("rst_out_carry_last", {30'd0, oc1, ol1}, 32'd0);
      chk("rst_in_ready3", {31'd0, r3}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, r1}, 32'd1);

      for (int i = 0; i < 12; i++) begin
         do_word(1, vt[i].a, vt[i].b, vt[i].f, vt[i].l, 0, vt[i].s, sum, cy, lst, lat);
         chk($sformatf("vec%0d_sum", i), {20'd0, sum}, {20'd0, vt[i].s});
         chk($sformatf("vec%0d_carry", i), {31'd0, cy}, {31'd0, vt[i].c});
         chk($sformatf("vec%0d_last", i), {31'd0, lst}, {31'd0, vt[i].l});
         chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      end

      // Backpressure for five cycles.
      do_word(1, 12'hFFF, 12'h001, 1'b1, 1'b1, 5, 12'h000, sum, cy, lst, lat);
      chk("bp_sum_final", {20'd0, sum}, 32'h000);
      chk("bp_carry_final", {31'd0, cy}, 32'd1);

      // Reset while the second word sits in its carry pass.
      do_word(1, 12'hFFF, 12'h001, 1'b1, 1'b0, 0, 12'h000, sum, cy, lst, lat);
      chk("rp_w0_carry", {31'd0, cy}, 32'd1);
      @(negedge clk);
      sel = 1; in_a = 12'h7FF; in_b = 12'h800; in_first = 1'b0; in_last = 1'b1; in_valid = 1'b1;
      chk("rp_ready", {31'd0, r1}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rp_pass2_add_in", {8'd0, ai1}, {8'd0, ilv(12'hFFF, 12'h001)});
      chk("rp_pass2_valid", {31'd0, ov1}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rp_rst_valid", {31'd0, ov1}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rp_rst_ready", {31'd0, r1}, 32'd1);
      do_word(1, 12'h001, 12'h001, 1'b0, 1'b1, 0, 12'h002, sum, cy, lst, lat);
      chk("rp_next_sum", {20'd0, sum}, 32'h002);
      chk("rp_next_carry", {31'd0, cy}, 32'd0);

      // Three-cycle settle instance.
      do_word(3, 12'h123, 12'h456, 1'b1, 1'b1, 0, 12'h579, sum, cy, lst, lat);
      chk("s3_sum", {20'd0, sum}, 32'h579);
      chk("s3_carry", {31'd0, cy}, 32'd0);
      chk("s3_lat", lat, 3);
      do_word(3, 12'hFFF, 12'h001, 1'b1, 1'b0, 0, 12'h000, sum, cy, lst, lat);
      chk("s3_w0_carry", {31'd0, cy}, 32'd1);
      do_word(3, 12'h7FF, 12'h800, 1'b0, 1'b1, 0, 12'h000, sum, cy, lst, lat);
      chk("s3_w1_sum", {20'd0, sum}, 32'h000);
      chk("s3_w1_carry", {31'd0, cy}, 32'd1);
      chk("s3_w1_lat", lat, 6);

      // Random multi-word transactions against a wide-integer model.
      for (int t = 0; t < 150; t++) begin
         s  = (t % 2 == 0) ? 1 : 3;
         nw = $urandom_range(1, 4);
         wa = '0; wb = '0;
         for (int i = 0; i < nw; i++) begin
            ra[i] = W'($urandom());
            rb[i] = W'($urandom());
            if ($urandom_range(0, 3) == 0) rb[i] = ~ra[i];
            wa = wa | (64'(ra[i]) << (W * i));
            wb = wb | (64'(rb[i]) << (W * i));
         end
         wt = wa + wb;
         prevc = 1'b0;
         for (int i = 0; i < nw; i++) begin
            m    = (64'd1 << (W * (i + 1))) - 64'd1;
            part = (wa & m) + (wb & m);
            es   = W'(wt >> (W * i));
            ec   = part[W * (i + 1)];
            do_word(s, ra[i], rb[i], (i == 0), (i == nw - 1), 0, es, sum, cy, lst, lat);
            chk($sformatf("rnd%0d_w%0d_sum", t, i), {20'd0, sum}, {20'd0, es});
            chk($sformatf("rnd%0d_w%0d_carry", t, i), {31'd0, cy}, {31'd0, ec});
            chk($sformatf("rnd%0d_w%0d_last", t, i), {31'd0, lst}, {31'd0, (i == nw - 1)});
            chk($sformatf("rnd%0d_w%0d_lat", t, i), lat, (i > 0 && prevc) ? 2 * s : s);
            prevc = ec;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
